// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants, register-select codes and engine state type for exp2_rsa.
package rsa_pkg;

  localparam int KEY_W_DEF   = 256;
  localparam int LATENCY_MAX = 140000;

  typedef enum logic [1:0] {
    SEL_A0 = 2'd0,
    SEL_A1 = 2'd1,
    SEL_A2 = 2'd2,
    SEL_A3 = 2'd3
  } reg_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SQR  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_SQR) || (s == ST_MUL);
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: p = a*b mod n, bit-serial interleaved shift-add, one multiplier bit per cycle.
// Requires a, b < n; latency is a fixed KEY_W cycles after start regardless of operands.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic [KEY_W-1:0] n,
  output logic             done,
  output logic [KEY_W-1:0] p
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [KEY_W-1:0] a_r;
  logic [KEY_W-1:0] b_r;
  logic [KEY_W-1:0] n_r;

  logic [KEY_W+1:0] n_ext_s;
  logic [KEY_W+1:0] dbl_s;
  logic [KEY_W+1:0] red1_s;
  logic [KEY_W+1:0] add_s;
  logic [KEY_W-1:0] p_next_s;

  // One step: r = 2r mod n, then r = (r + a*b_i) mod n, both reductions a single subtract.
  always_comb begin
    n_ext_s = {2'b00, n_r};
    dbl_s   = {1'b0, p, 1'b0};
    if (dbl_s >= n_ext_s) begin
      red1_s = dbl_s - n_ext_s;
    end else begin
      red1_s = dbl_s;
    end
    if (b_r[KEY_W-1]) begin
      add_s = red1_s + {2'b00, a_r};
    end else begin
      add_s = red1_s;
    end
    if (add_s >= n_ext_s) begin
      p_next_s = KEY_W'(add_s - n_ext_s);
    end else begin
      p_next_s = KEY_W'(add_s);
    end
  end

  // Operand capture, iteration counter and one-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done   <= 1'b0;
      cnt_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      p      <= '0;
    end else begin
      done <= 1'b0;
      if (!busy_r) begin
        if (start) begin
          a_r    <= a;
          b_r    <= b;
          n_r    <= n;
          p      <= '0;
          cnt_r  <= CNT_W'(KEY_W);
          busy_r <= 1'b1;
        end
      end else begin
        p     <= p_next_s;
        b_r   <= {b_r[KEY_W-2:0], 1'b0};
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exp2_rsa.sv
// exp2_rsa: byte-addressed RSA engine computing a0 = a1^a2 mod a3 by square-and-multiply.
// Build option RSA_REG_READBACK_EN: the read port returns the register chosen by reg_sel.
module exp2_rsa
  import rsa_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       ready,
  input  logic       we,
  input  logic       oe,
  input  logic       start,
  input  logic [1:0] reg_sel,
  input  logic [4:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       clk_o,
  output logic       reset_o,
  output logic       ready_o,
  output logic       we_o,
  output logic       oe_o,
  output logic       start_o,
  output logic [1:0] reg_sel_o,
  output logic [4:0] addr_o,
  output logic [7:0] data_i_o
);

  localparam int IDX_W  = $clog2(KEY_W);
  localparam int NBYTES = KEY_W / 8;
  localparam logic [KEY_W-1:0] ONE = {{(KEY_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [KEY_W-1:0] a0_r, a1_r, a2_r, a3_r;
  logic [KEY_W-1:0] acc_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic             mm_start_r;
  logic [KEY_W-1:0] mm_a_r, mm_b_r;
  logic             mm_done_s;
  logic [KEY_W-1:0] mm_p_s;
  logic [KEY_W-1:0] next_acc_s;
  logic [KEY_W-1:0] cur_word_s, new_word_s, rd_src_s;
  logic [7:0]       rd_byte_s;
  logic             host_wr_s;

  assign clk_o     = clk;
  assign reset_o   = reset;
  assign ready_o   = ready;
  assign we_o      = we;
  assign oe_o      = oe;
  assign start_o   = start;
  assign reg_sel_o = reg_sel;
  assign addr_o    = addr;
  assign data_i_o  = data_i;

  rsa_modmul #(.KEY_W(KEY_W)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (mm_start_r),
    .a     (mm_a_r),
    .b     (mm_b_r),
    .n     (a3_r),
    .done  (mm_done_s),
    .p     (mm_p_s)
  );

  // Host byte write: merge data_i into the addressed byte of the selected register.
  always_comb begin
    case (reg_sel_t'(reg_sel))
      SEL_A1:  cur_word_s = a1_r;
      SEL_A2:  cur_word_s = a2_r;
      SEL_A3:  cur_word_s = a3_r;
      default: cur_word_s = a0_r;
    endcase
    new_word_s = cur_word_s;
    for (int k = 0; k < NBYTES; k++) begin
      new_word_s[8*k +: 8] = (addr == 5'(k)) ? data_i : cur_word_s[8*k +: 8];
    end
    host_wr_s = we && !is_busy(state_r);
  end

  // Operand registers; a0 is owned by the engine and never host-written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a1_r <= '0;
      a2_r <= '0;
      a3_r <= '0;
    end else if (host_wr_s) begin
      case (reg_sel_t'(reg_sel))
        SEL_A1:  a1_r <= new_word_s;
        SEL_A2:  a2_r <= new_word_s;
        SEL_A3:  a3_r <= new_word_s;
        default: ;
      endcase
    end
  end

  // Byte read port, zero while oe is low.
  always_comb begin
`ifdef RSA_REG_READBACK_EN
    case (reg_sel_t'(reg_sel))
      SEL_A1:  rd_src_s = a1_r;
      SEL_A2:  rd_src_s = a2_r;
      SEL_A3:  rd_src_s = a3_r;
      default: rd_src_s = a0_r;
    endcase
`else
    rd_src_s = a0_r;
`endif
    rd_byte_s = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      rd_byte_s = rd_byte_s | ((addr == 5'(k)) ? rd_src_s[8*k +: 8] : 8'h00);
    end
    if (oe) begin
      data_o = rd_byte_s;
    end else begin
      data_o = 8'h00;
    end
  end

  // The MUL product is always computed but kept only when the exponent bit is set.
  always_comb begin
    if (a2_r[bit_idx_r]) begin
      next_acc_s = mm_p_s;
    end else begin
      next_acc_s = acc_r;
    end
  end

  // Exponent-loop FSM: MSB-first, one SQR and one MUL per bit for fixed latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ready      <= 1'b0;
      a0_r       <= '0;
      acc_r      <= '0;
      bit_idx_r  <= '0;
      mm_start_r <= 1'b0;
      mm_a_r     <= '0;
      mm_b_r     <= '0;
    end else begin
      mm_start_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_LOAD;
            ready   <= 1'b0;
          end
        end
        ST_LOAD: begin
          acc_r      <= ONE;
          bit_idx_r  <= IDX_W'(KEY_W - 1);
          mm_a_r     <= ONE;
          mm_b_r     <= ONE;
          mm_start_r <= 1'b1;
          state_r    <= ST_SQR;
        end
        ST_SQR: begin
          if (mm_done_s) begin
            acc_r      <= mm_p_s;
            mm_a_r     <= mm_p_s;
            mm_b_r     <= a1_r;
            mm_start_r <= 1'b1;
            state_r    <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mm_done_s) begin
            acc_r <= next_acc_s;
            if (bit_idx_r == IDX_W'(0)) begin
              a0_r    <= next_acc_s;
              ready   <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              bit_idx_r  <= bit_idx_r - IDX_W'(1);
              mm_a_r     <= next_acc_s;
              mm_b_r     <= next_acc_s;
              mm_start_r <= 1'b1;
              state_r    <= ST_SQR;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp2_rsa.sv
// tb_exp2_rsa: directed self-checking bench for exp2_rsa, built with a 32-bit key width.
module tb_exp2_rsa;
  import rsa_pkg::*;

  localparam int KW     = 32;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we = 1'b0;
  logic       oe = 1'b0;
  logic       start = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [4:0] addr = 5'd0;
  logic [7:0] data_i = 8'h00;
  logic       ready;
  logic [7:0] data_o;
  logic       clk_o, reset_o, ready_o, we_o, oe_o, start_o;
  logic [1:0] reg_sel_o;
  logic [4:0] addr_o;
  logic [7:0] data_i_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned t0;
  int          lat, lat_ref, lat_b;
  logic [31:0] word;
  logic [7:0]  byte_v;

  exp2_rsa #(.KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .we(we), .oe(oe), .start(start),
    .reg_sel(reg_sel), .addr(addr), .data_i(data_i), .data_o(data_o),
    .clk_o(clk_o), .reset_o(reset_o), .ready_o(ready_o), .we_o(we_o), .oe_o(oe_o),
    .start_o(start_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_i_o(data_i_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [1:0] sel, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; reg_sel = sel; addr = a; data_i = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wr_word(input logic [1:0] sel, input logic [31:0] v);
    for (int k = 0; k < 4; k++) wr_byte(sel, 5'(k), v[8*k +: 8]);
  endtask

  task automatic rd_byte(input logic [1:0] sel, input logic [4:0] a, output logic [7:0] b);
    @(negedge clk);
    oe = 1'b1; reg_sel = sel; addr = a;
    #1;
    b = data_o;
    oe = 1'b0;
  endtask

  task automatic rd_word(input logic [1:0] sel, output logic [31:0] v);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      rd_byte(sel, 5'(k), b);
      v[8*k +: 8] = b;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    while (ready !== 1'b1 && (cyc - t0) < BUDGET) @(negedge clk);
    cycles = int'(cyc - t0);
    check("ready_within_budget", {31'd0, ready}, 32'd1);
  endtask

  task automatic rsa(input string tag, input logic [31:0] n, input logic [31:0] d,
                     input logic [31:0] c, input logic [31:0] exp, output int cycles);
    logic [31:0] w;
    wr_word(2'd3, n);
    wr_word(2'd2, d);
    wr_word(2'd1, c);
    pulse_start();
    wait_ready(cycles);
    rd_word(2'd0, w);
    check(tag, w, exp);
  endtask

  initial begin
    // reset state
    #2;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_mirror", {31'd0, reset_o}, 32'd0);
    check("reset_oe_low", {24'd0, data_o}, 32'd0);
    rd_word(2'd0, word);
    check("reset_a0", word, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // textbook key: 2790^2753 mod 3233 = 65
    rsa("m_2753", 32'd3233, 32'd2753, 32'd2790, 32'h41, lat_ref);
    check("lat_bound", {31'd0, lat_ref <= LATENCY_MAX}, 32'd1);
    check("ready_mirror", {31'd0, ready_o}, 32'd1);
    rd_byte(2'd3, 5'd0, byte_v);
`ifdef RSA_REG_READBACK_EN
    check("readback_n_b0", {24'd0, byte_v}, 32'hA1);
`else
    check("readback_a0_b0", {24'd0, byte_v}, 32'h41);
`endif
    @(negedge clk);
    oe = 1'b0; reg_sel = 2'd0; addr = 5'd0;
    #1;
    check("oe_low_zero", {24'd0, data_o}, 32'd0);
    wr_byte(2'd0, 5'd0, 8'h55);
    rd_byte(2'd0, 5'd0, byte_v);
    check("a0_write_ignored", {24'd0, byte_v}, 32'h41);

    rsa("d_zero", 32'd3233, 32'd0, 32'd2790, 32'd1, lat);
    rsa("d_one", 32'd3233, 32'd1, 32'd2790, 32'h0AE6, lat);
    rsa("c_zero", 32'd3233, 32'd5, 32'd0, 32'd0, lat);
    rsa("enc_65", 32'd3233, 32'd17, 32'd65, 32'd2790, lat);
    rsa("enc_2", 32'd3233, 32'd17, 32'd2, 32'd1752, lat_b);
    check("lat_equal_c", lat_b, lat);
    check("lat_equal_d", lat_b, lat_ref);

    // full-width operands, n = 2^32-5 (prime)
    rsa("fermat_2", 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd2, 32'd1, lat);
    rsa("fermat_c", 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h1234_5678, 32'h1234_5678, lat);
    rsa("nm1_sq", 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFA, 32'd1, lat);
    check("lat_equal_wide", lat, lat_ref);

    // stray start and writes while busy
    wr_word(2'd3, 32'd3233);
    wr_word(2'd2, 32'd2753);
    wr_word(2'd1, 32'd2790);
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_byte(2'd1, 5'd0, 8'hFF);
    wr_byte(2'd3, 5'd0, 8'h00);
    wr_byte(2'd2, 5'd1, 8'h00);
    wait_ready(lat);
    rd_word(2'd0, word);
    check("busy_perturb", word, 32'h41);
    check("busy_perturb_lat", lat, lat_ref);

    // asynchronous reset mid-computation
    pulse_start();
    repeat (200) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    rd_word(2'd0, word);
    check("midrst_a0", word, 32'd0);
`ifdef RSA_REG_READBACK_EN
    rd_word(2'd1, word);
    check("midrst_a1", word, 32'd0);
    rd_word(2'd2, word);
    check("midrst_a2", word, 32'd0);
    rd_word(2'd3, word);
    check("midrst_a3", word, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rsa("after_reset", 32'd3233, 32'd2753, 32'd2790, 32'h41, lat);
    check("after_reset_lat", lat, lat_ref);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
